// File: rtl/stage2_maxpool_pkg.sv
// Shared sizing for the stage2 max-pool block: channel count, value width and frame geometry.
package stage2_maxpool_pkg;

  localparam int ST2_POOL_CI  = 3;
  localparam int ST2_POOL_IBW = 32;
  localparam int ST2_POOL_X   = 8;
  localparam int ST2_POOL_Y   = 8;
  localparam int ST2_POOL_OX  = ST2_POOL_X / 2;
  localparam int ST2_POOL_OY  = ST2_POOL_Y / 2;

  // Index width for a buffer of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage2_pool_ch.sv
// One channel of 2x2 stride-2 max pooling: horizontal pair register, half-row line buffer
// and the registered pooled result.
module stage2_pool_ch
  import stage2_maxpool_pkg::*;
#(
  parameter int IBW = ST2_POOL_IBW,
  parameter int OX  = ST2_POOL_OX,
  localparam int IDX_W = idx_width(OX)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  col_odd,
  input  logic                  row_odd,
  input  logic [IDX_W-1:0]      idx,
  input  logic signed [IBW-1:0] data,
  output logic signed [IBW-1:0] pool
);

  logic signed [IBW-1:0] h_reg;
  logic signed [IBW-1:0] hmax;
  logic signed [IBW-1:0] vmax;
  logic signed [IBW-1:0] line_buf [OX];

  always_comb begin
    hmax = (data > h_reg) ? data : h_reg;
    vmax = (line_buf[idx] > hmax) ? line_buf[idx] : hmax;
  end

  // Even rows park the horizontal max; odd rows read it back before the next even row overwrites it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_reg <= '0;
      pool  <= '0;
      for (int i = 0; i < OX; i++) begin
        line_buf[i] <= '0;
      end
    end else if (in_valid) begin
      if (!col_odd) begin
        h_reg <= data;
      end else if (!row_odd) begin
        line_buf[idx] <= hmax;
      end else begin
        pool <= vmax;
      end
    end
  end

endmodule

// File: rtl/stage2_maxpool.sv
// Stage2 max pool: tracks the raster position of the incoming stream and fans each point
// out to one pooling lane per channel; emits a 4x4 pooled stream with a frame-done pulse.
module stage2_maxpool
  import stage2_maxpool_pkg::*;
#(
  parameter int CH   = ST2_POOL_CI,
  parameter int IBW  = ST2_POOL_IBW,
  parameter int IN_X = ST2_POOL_X,
  parameter int IN_Y = ST2_POOL_Y
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_in_valid,
  input  logic [CH*IBW-1:0] i_in_fmap,
  output logic              o_ot_valid,
  output logic [CH*IBW-1:0] o_ot_fmap,
  output logic              o_ot_done
);

  localparam int OX    = IN_X / 2;
  localparam int COL_W = idx_width(IN_X);
  localparam int ROW_W = idx_width(IN_Y);
  localparam int IDX_W = idx_width(OX);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             row_last;
  logic [IDX_W-1:0] idx;

  always_comb begin
    col_last = (col == COL_W'(IN_X - 1));
    row_last = (row == ROW_W'(IN_Y - 1));
    idx      = IDX_W'(col >> 1);
  end

  // Raster counters advance only on valid points; the frame wraps straight into the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      o_ot_valid <= 1'b0;
      o_ot_done  <= 1'b0;
    end else begin
      o_ot_valid <= i_in_valid & col[0] & row[0];
      o_ot_done  <= i_in_valid & col_last & row_last;
      if (i_in_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    stage2_pool_ch #(
      .IBW (IBW),
      .OX  (OX)
    ) u_pool_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (i_in_valid),
      .col_odd  (col[0]),
      .row_odd  (row[0]),
      .idx      (idx),
      .data     (i_in_fmap[k*IBW +: IBW]),
      .pool     (o_ot_fmap[k*IBW +: IBW])
    );
  end

endmodule

// File: tb/tb_stage2_maxpool.sv
// Self-checking bench for stage2_maxpool: random and directed frames compared against a
// window-max reference built from the full input frame.
module tb_stage2_maxpool;

  localparam int CH   = 3;
  localparam int IBW  = 32;
  localparam int IN_X = 8;
  localparam int IN_Y = 8;
  localparam int NPTS = IN_X * IN_Y;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_in_valid;
  logic [CH*IBW-1:0] i_in_fmap;
  logic              o_ot_valid;
  logic [CH*IBW-1:0] o_ot_fmap;
  logic              o_ot_done;

  int checks = 0;
  int errors = 0;
  int pos    = 0;
  int seen   = 0;
  int dones  = 0;
  logic [CH*IBW-1:0]     last_out = '0;
  logic signed [IBW-1:0] frame [IN_Y][IN_X][CH];

  stage2_maxpool #(
    .CH   (CH),
    .IBW  (IBW),
    .IN_X (IN_X),
    .IN_Y (IN_Y)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (i_in_valid),
    .i_in_fmap  (i_in_fmap),
    .o_ot_valid (o_ot_valid),
    .o_ot_fmap  (o_ot_fmap),
    .o_ot_done  (o_ot_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CH*IBW-1:0] obs, input logic [CH*IBW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [IBW-1:0] smax(input logic signed [IBW-1:0] a, input logic signed [IBW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // mode 0: ramp on ch0 (+off), negated ramp on ch1, random ch2; mode 1: channel independence pattern
  function automatic logic signed [IBW-1:0] gen(input int mode, input int r, input int c, input int k, input int off);
    int v;
    v = 0;
    if (mode == 0) begin
      case (k)
        0:       v = r * IN_X + c + off;
        1:       v = -(r * IN_X + c);
        default: v = int'($urandom);
      endcase
    end else begin
      case (k)
        0:       v = 5;
        1:       v = (r % 2 == 0 && c % 2 == 0) ? 100 : int'($urandom_range(0, 99)) - 50;
        default: v = (r % 2 == 1 && c % 2 == 1) ? 77 : int'($urandom_range(0, 76)) - 50;
      endcase
    end
    return IBW'(v);
  endfunction

  task automatic observe();
    if (o_ot_valid === 1'b1) seen++;
    if (o_ot_done === 1'b1) dones++;
  endtask

  task automatic applyStimulus(input int mode, input int off);
    int r;
    int c;
    logic [CH*IBW-1:0] word;
    logic exp_v;
    logic exp_d;
    r = pos / IN_X;
    c = pos % IN_X;
    for (int k = 0; k < CH; k++) begin
      frame[r][c][k] = gen(mode, r, c, k, off);
      word[k*IBW +: IBW] = frame[r][c][k];
    end
    i_in_valid = 1'b1;
    i_in_fmap  = word;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_in_fmap  = {$urandom, $urandom, $urandom};
    exp_v = (r % 2 == 1) && (c % 2 == 1);
    exp_d = (r == IN_Y - 1) && (c == IN_X - 1);
    if (exp_v) begin
      for (int k = 0; k < CH; k++) begin
        last_out[k*IBW +: IBW] = smax(smax(frame[r-1][c-1][k], frame[r-1][c][k]),
                                      smax(frame[r][c-1][k], frame[r][c][k]));
      end
    end
    observe();
    check("valid", {{(CH*IBW-1){1'b0}}, o_ot_valid}, {{(CH*IBW-1){1'b0}}, exp_v});
    check("done", {{(CH*IBW-1){1'b0}}, o_ot_done}, {{(CH*IBW-1){1'b0}}, exp_d});
    check("fmap", o_ot_fmap, last_out);
    pos = (pos + 1) % NPTS;
  endtask

  task automatic checkOutput(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      observe();
      check("idle_valid", {{(CH*IBW-1){1'b0}}, o_ot_valid}, '0);
      check("idle_done", {{(CH*IBW-1){1'b0}}, o_ot_done}, '0);
      check("idle_fmap", o_ot_fmap, last_out);
    end
  endtask

  task automatic send_frame(input int mode, input int off, input int gap_max, input int npts);
    for (int i = 0; i < npts; i++) begin
      applyStimulus(mode, off);
      if (gap_max > 0) checkOutput(int'($urandom_range(0, gap_max)));
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {{(CH*IBW-1){1'b0}}, o_ot_valid}, '0);
    check("reset_done", {{(CH*IBW-1){1'b0}}, o_ot_done}, '0);
    check("reset_fmap", o_ot_fmap, '0);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput(2);

    $display("[TB] ramp frame, contiguous");
    seen = 0; dones = 0;
    send_frame(0, 0, 0, NPTS);
    check("ramp_last_ch0", {64'd0, o_ot_fmap[IBW-1:0]}, {64'd0, 32'd63});
    check("ramp_last_ch1", {64'd0, o_ot_fmap[2*IBW-1:IBW]}, {64'd0, 32'hFFFF_FFCA});
    check("ramp_count", 96'(seen), 96'(16));
    check("ramp_dones", 96'(dones), 96'(1));

    $display("[TB] channel independence with gaps");
    seen = 0;
    send_frame(1, 0, 3, NPTS);
    check("indep_value", o_ot_fmap, {32'd77, 32'd100, 32'd5});
    check("indep_count", 96'(seen), 96'(16));

    $display("[TB] ramp frame with random gaps");
    seen = 0;
    send_frame(0, 0, 5, NPTS);
    check("gap_count", 96'(seen), 96'(16));
    check("gap_last_ch0", {64'd0, o_ot_fmap[IBW-1:0]}, {64'd0, 32'd63});

    $display("[TB] back-to-back frames");
    seen = 0; dones = 0;
    send_frame(0, 0, 0, NPTS);
    send_frame(0, 1000, 0, NPTS);
    check("b2b_count", 96'(seen), 96'(32));
    check("b2b_dones", 96'(dones), 96'(2));
    check("b2b_last_ch0", {64'd0, o_ot_fmap[IBW-1:0]}, {64'd0, 32'd1063});

    $display("[TB] reset mid-frame");
    send_frame(0, 0, 0, 37);
    #2;
    reset_n = 1'b0;
    #2;
    check("midrst_valid", {{(CH*IBW-1){1'b0}}, o_ot_valid}, '0);
    check("midrst_fmap", o_ot_fmap, '0);
    @(negedge clk);
    reset_n  = 1'b1;
    pos      = 0;
    last_out = '0;
    seen = 0; dones = 0;
    checkOutput(1);
    send_frame(0, 0, 0, NPTS);
    check("midrst_count", 96'(seen), 96'(16));
    check("midrst_dones", 96'(dones), 96'(1));
    check("midrst_last_ch0", {64'd0, o_ot_fmap[IBW-1:0]}, {64'd0, 32'd63});
    checkOutput(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
